// File: rtl/line_clear_engine.sv
// Purpose: compacts the Tetris board held in shared VRAM by removing every full row, bottom to top.
// Latency: 3 cycles per row scanned, plus 2 per retained row that moves down, plus 2 per cleared row; done at 3*ROWS+2 minimum.
// Backpressure: none; VRAM answers every read one cycle later, and start is ignored unless the engine is idle.
module line_clear_engine #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int COLOR_OFFSET = 40,
    parameter int ADDR_W       = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic [3:0]        mem_byte_en,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [3:0] {
        IDLE,
        RD_OCC,
        RD_COL,
        EVAL,
        WR_OCC,
        WR_COL,
        FILL_OCC,
        FILL_COL,
        DONE
    } state_t;

    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COL_OFF  = ADDR_W'(COLOR_OFFSET);

    state_t      state;
    logic [4:0]  rd;
    logic [4:0]  wr;
    logic [4:0]  cnt;
    logic [4:0]  f;
    logic [31:0] occ;
    logic [31:0] col;
    logic        row_full;

    // Only the playfield bits decide fullness; the upper bits ride along untouched.
    assign row_full    = &occ[COLS-1:0];
    assign mem_byte_en = 4'hF;

    // Row index to VRAM word address, zero-extended.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [4:0] r);
        return ADDR_W'(r);
    endfunction

    // Pass sequencer. Every memory output is registered, so each branch loads the
    // address/data/enable that the *next* state must present during its own cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= 5'd0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            mem_we        <= 1'b0;
            rd            <= 5'd0;
            wr            <= 5'd0;
            cnt           <= 5'd0;
            f             <= 5'd0;
            occ           <= 32'd0;
            col           <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd            <= LAST_ROW;
                        wr            <= LAST_ROW;
                        cnt           <= 5'd0;
                        busy          <= 1'b1;
                        lines_cleared <= 5'd0;
                        mem_addr      <= row_addr(LAST_ROW);
                        mem_we        <= 1'b0;
                        state         <= RD_OCC;
                    end
                end
                RD_OCC: begin
                    mem_addr <= row_addr(rd) + COL_OFF;
                    state    <= RD_COL;
                end
                RD_COL: begin
                    occ   <= mem_rdata;
                    state <= EVAL;
                end
                EVAL: begin
                    col <= mem_rdata;
                    if (!row_full && wr != rd) begin
                        // Retained row below a gap: copy it down to the write row.
                        mem_addr  <= row_addr(wr);
                        mem_wdata <= occ;
                        mem_we    <= 1'b1;
                        state     <= WR_OCC;
                    end else begin
                        if (row_full) begin
                            cnt <= cnt + 5'd1;
                        end else begin
                            wr <= wr - 5'd1;
                        end
                        if (rd == 5'd0) begin
                            // A full row here makes cnt non-zero, so the fill writes immediately.
                            f         <= 5'd0;
                            mem_addr  <= '0;
                            mem_wdata <= 32'd0;
                            mem_we    <= row_full || (cnt != 5'd0);
                            state     <= FILL_OCC;
                        end else begin
                            rd       <= rd - 5'd1;
                            mem_addr <= row_addr(rd - 5'd1);
                            mem_we   <= 1'b0;
                            state    <= RD_OCC;
                        end
                    end
                end
                WR_OCC: begin
                    mem_addr  <= row_addr(wr) + COL_OFF;
                    mem_wdata <= col;
                    state     <= WR_COL;
                end
                WR_COL: begin
                    wr <= wr - 5'd1;
                    if (rd == 5'd0) begin
                        f         <= 5'd0;
                        mem_addr  <= '0;
                        mem_wdata <= 32'd0;
                        mem_we    <= (cnt != 5'd0);
                        state     <= FILL_OCC;
                    end else begin
                        rd       <= rd - 5'd1;
                        mem_addr <= row_addr(rd - 5'd1);
                        mem_we   <= 1'b0;
                        state    <= RD_OCC;
                    end
                end
                FILL_OCC: begin
                    if (f == cnt) begin
                        mem_we        <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        lines_cleared <= cnt;
                        state         <= DONE;
                    end else begin
                        mem_addr  <= row_addr(f) + COL_OFF;
                        mem_wdata <= 32'd0;
                        mem_we    <= 1'b1;
                        state     <= FILL_COL;
                    end
                end
                FILL_COL: begin
                    f         <= f + 5'd1;
                    mem_addr  <= row_addr(f + 5'd1);
                    mem_wdata <= 32'd0;
                    mem_we    <= ((f + 5'd1) != cnt);
                    state     <= FILL_OCC;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Purpose: checks line_clear_engine against a row-list model of compaction with a VRAM model attached.
// Latency: checks the done cycle, the write count and the busy window of every pass.
// Backpressure: none; the VRAM model answers reads one cycle after the address, like the real dual-port RAM.
module tb_line_clear_engine;

    localparam int ROWS = 20;
    localparam int BASE_CYC = 3 * ROWS + 2;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  lines_cleared;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;

    line_clear_engine dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_byte_en   (mem_byte_en),
        .mem_rdata     (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // VRAM model: board image in words 0..19 (occupancy) and 40..59 (colour).
    logic [31:0] vram [64];
    logic [31:0] bo [ROWS];
    logic [31:0] bc [ROWS];
    logic        load_req;
    int          wild_wr;

    initial wild_wr = 0;

    always @(posedge CLK) begin
        if (load_req) begin
            for (int i = 0; i < ROWS; i++) begin
                vram[i]      <= bo[i];
                vram[i + 40] <= bc[i];
            end
        end else if (mem_we) begin
            vram[mem_addr[5:0]] <= mem_wdata;
            if (mem_addr[11:6] != 6'd0) wild_wr <= wild_wr + 1;
        end
        mem_rdata <= vram[mem_addr[5:0]];
    end

    int total;
    int bad;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Expected image from the rule "keep the non-full rows in order, packed at the bottom".
    logic [31:0] exp_o [ROWS];
    logic [31:0] exp_c [ROWS];

    task automatic model(output int lines, output int cyc);
        int  k;
        int  moved;
        bit  seen_full;
        k = ROWS - 1;
        moved = 0;
        seen_full = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (bo[r][9:0] == 10'h3FF) begin
                seen_full = 1;
            end else begin
                exp_o[k] = bo[r];
                exp_c[k] = bc[r];
                k--;
                if (seen_full) moved++;
            end
        end
        lines = k + 1;
        for (int r = 0; r <= k; r++) begin
            exp_o[r] = 32'd0;
            exp_c[r] = 32'd0;
        end
        cyc = BASE_CYC + 2 * moved + 2 * lines;
    endtask

    task automatic load_board();
        @(negedge CLK) load_req = 1'b1;
        @(negedge CLK) load_req = 1'b0;
    endtask

    int r_dcyc;
    int r_we;
    int r_busy;
    int r_dones;

    // One pass from a start pulse; mode 1 adds stray starts at cycle 20 and around DONE.
    task automatic run_pass(input int mode, input int stray_exp);
        int cyc;
        @(negedge CLK) start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        cyc = 1;
        r_dcyc = -1;
        r_we = 0;
        r_busy = 0;
        r_dones = 0;
        while (cyc < 400) begin
            if (mem_we) r_we++;
            if (busy) r_busy++;
            if (done) begin
                r_dones++;
                if (r_dcyc < 0) r_dcyc = cyc;
            end
            if (mode == 1) start = (cyc == 20) || (cyc >= stray_exp - 3 && cyc <= stray_exp);
            if (r_dcyc >= 0 && cyc >= r_dcyc + 4) break;
            @(posedge CLK);
            #1 cyc++;
        end
        start = 1'b0;
        if (r_dcyc < 0) chk("timeout_waiting_done", cyc, 0);
    endtask

    task automatic check_pass(input string nm, input int exp_lines, input int exp_cyc);
        int mism;
        int ml;
        int mc;
        int w0;
        w0 = wild_wr;
        model(ml, mc);
        run_pass(0, 0);
        chk({nm, "_lines"}, lines_cleared, exp_lines);
        chk({nm, "_done_cycle"}, r_dcyc, exp_cyc);
        chk({nm, "_write_count"}, r_we, exp_cyc - BASE_CYC);
        chk({nm, "_busy_cycles"}, r_busy, exp_cyc - 1);
        chk({nm, "_done_pulses"}, r_dones, 1);
        chk({nm, "_stray_addr_writes"}, wild_wr - w0, 0);
        mism = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (vram[r] !== exp_o[r]) mism++;
            if (vram[r + 40] !== exp_c[r]) mism++;
        end
        chk({nm, "_image_mismatch_words"}, mism, 0);
    endtask

    typedef struct {
        logic [19:0] full_mask;
        int          ra;
        logic [31:0] oa;
        logic [31:0] ca;
        int          rb;
        logic [31:0] ob;
        logic [31:0] cb;
        int          chk_row;
        logic [31:0] chk_o;
        logic [31:0] chk_c;
        int          exp_lines;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [5];

    task automatic build_board(input vec_t v);
        for (int r = 0; r < ROWS; r++) begin
            if (v.full_mask[r]) begin
                bo[r] = 32'h3FF | (32'(r) << 20);
                bc[r] = 32'hC000 + 32'(r);
            end else begin
                bo[r] = 32'd0;
                bc[r] = 32'd0;
            end
        end
        if (v.ra >= 0) begin bo[v.ra] = v.oa; bc[v.ra] = v.ca; end
        if (v.rb >= 0) begin bo[v.rb] = v.ob; bc[v.rb] = v.cb; end
    endtask

    initial begin
        int          ml;
        int          mc;
        logic [31:0] tmp;
        total = 0;
        bad = 0;
        load_req = 1'b0;
        start = 1'b0;
        RESET = 1'b1;

        //                full      ra  oa            ca            rb  ob       cb     row occ     col           lines cyc
        vecs[0] = '{20'h00000, -1, 32'h0,        32'h0,        -1, 32'h0,   32'h0,  19, 32'h0,   32'h0,        0,  62};
        vecs[1] = '{20'h80000, 18, 32'h001,      32'h7,        -1, 32'h0,   32'h0,  19, 32'h001, 32'h7,        1,  102};
        vecs[2] = '{20'hB0000, 18, 32'h2AA,      32'h12345678, -1, 32'h0,   32'h0,  19, 32'h2AA, 32'h12345678, 3,  102};
        vecs[3] = '{20'h00000, 10, 32'h800003FF, 32'h55,       11, 32'h3FE, 32'h66, 11, 32'h3FE, 32'h66,       1,  84};
        vecs[4] = '{20'hFFFFF, -1, 32'h0,        32'h0,        -1, 32'h0,   32'h0,  0,  32'h0,   32'h0,        20, 102};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_we", mem_we, 0);
        chk("byte_en", mem_byte_en, 4'hF);
        @(negedge CLK) RESET = 1'b0;
        repeat (2) @(posedge CLK);

        // Directed boards from the table.
        for (int i = 0; i < 5; i++) begin
            build_board(vecs[i]);
            load_board();
            check_pass($sformatf("vec%0d", i), vecs[i].exp_lines, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_row%0d_occ", i, vecs[i].chk_row), vram[vecs[i].chk_row], vecs[i].chk_o);
            chk($sformatf("vec%0d_row%0d_col", i, vecs[i].chk_row), vram[vecs[i].chk_row + 40], vecs[i].chk_c);
        end
        chk("vec1_row0_occ", vram[0], 0);
        chk("vec3_row10_upper_bits_cleared_row", vram[10], 0);

        // Stray start at cycle 20 and start held high through DONE.
        build_board(vecs[1]);
        load_board();
        run_pass(1, vecs[1].exp_cyc);
        chk("stray_done_pulses", r_dones, 1);
        chk("stray_done_cycle", r_dcyc, vecs[1].exp_cyc);
        chk("stray_busy_cycles", r_busy, vecs[1].exp_cyc - 1);
        chk("stray_lines", lines_cleared, 1);
        chk("stray_row19_occ", vram[19], 32'h001);

        // Reset at cycle 30 of a four-line clear, then a clean rerun.
        build_board('{20'hF0000, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4, 102});
        load_board();
        @(negedge CLK) start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (29) @(posedge CLK);
        #1;
        chk("midpass_busy", busy, 1);
        RESET = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_lines", lines_cleared, 0);
        @(negedge CLK) RESET = 1'b0;
        repeat (2) @(posedge CLK);
        load_board();
        check_pass("after_reset", 4, 102);

        // Random boards against the model.
        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < ROWS; r++) begin
                tmp = $urandom;
                if ($urandom_range(0, 3) == 0) bo[r] = {tmp[31:10], 10'h3FF};
                else bo[r] = {tmp[31:10], 10'($urandom_range(0, 1022))};
                bc[r] = $urandom;
            end
            model(ml, mc);
            load_board();
            check_pass($sformatf("rand%0d", n), ml, mc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
